seq_magnitude_comparator: RTL and testbench



---
 rtl/cmp_pkg.sv | 28 ++
 rtl/chunk_cmp.sv | 19 +
 rtl/seq_magnitude_comparator.sv | 170 +++++++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmp_pkg;

    // Controller states: waiting for operands, scanning digits, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot result encoding; bit order matches {lt, gt, eq}.
    localparam logic [2:0] RES_EQ = 3'b001;
    localparam logic [2:0] RES_GT = 3'b010;
    localparam logic [2:0] RES_LT = 3'b100;

    // Width of a counter that can hold values 0..nchunk inclusive.
    function automatic int cnt_width(input int nchunk);
        return (nchunk < 1) ? 1 : $clog2(nchunk + 1);
    endfunction

    // Width of an index that addresses digits 0..nchunk-1 (at least one bit).
    function automatic int idx_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Purpose: unsigned compare of one DIGIT-bit slice of each operand.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module chunk_cmp #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_dig,
    output logic             d_eq,
    output logic             d_gt
);

    // Equality and unsigned greater-than of the current digit pair.
    always_comb begin
        d_eq = (a_dig == b_dig);
        d_gt = (a_dig > b_dig);
    end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Purpose: MSB-first multi-cycle compare of two WIDTH-bit operands, DIGIT bits per clock, unsigned or signed.
// Latency: `cycles` edges from accept to out_valid (1..NCHUNK; always NCHUNK when EARLY_EXIT=0).
// Backpressure: in_ready only in IDLE; DONE holds the result until out_ready, no bypass back to IDLE.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DIGIT      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH-1:0]                    a,
    input  logic [WIDTH-1:0]                    b,
    input  logic                                signed_mode,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                eq,
    output logic                                gt,
    output logic                                lt,
    output logic [cnt_width(WIDTH/DIGIT)-1:0]   cycles
);

    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int CNT_W  = cnt_width(NCHUNK);
    localparam int IDX_W  = idx_width(NCHUNK);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam logic [CNT_W-1:0] NCHUNK_C = CNT_W'(NCHUNK);
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

    state_t state, state_nxt;

    // Operands stored as digit arrays so the active digit is a plain index.
    logic [NCHUNK-1:0][DIGIT-1:0] a_q;
    logic [NCHUNK-1:0][DIGIT-1:0] b_q;
    logic [IDX_W-1:0]             idx;

    // First-difference latch: once set, later digits cannot change the outcome.
    logic                         found_q;
    logic                         found_gt_q;

    logic [2:0]                   res_q;
    logic [CNT_W-1:0]             cycles_q;

    logic                         d_eq;
    logic                         d_gt;
    logic                         any_diff;
    logic                         diff_gt;
    logic                         finish;
    logic [2:0]                   res_nxt;
    logic [CNT_W-1:0]             cycles_nxt;
    logic                         accept;
    logic                         release_out;

    chunk_cmp #(
        .DIGIT (DIGIT)
    ) u_chunk_cmp (
        .a_dig (a_q[idx]),
        .b_dig (b_q[idx]),
        .d_eq  (d_eq),
        .d_gt  (d_gt)
    );

    // Per-digit decision: merge this digit with any earlier difference and decide whether to stop.
    always_comb begin
        any_diff   = found_q || !d_eq;
        diff_gt    = found_q ? found_gt_q : d_gt;
        finish     = (idx == '0) || ((EARLY_EXIT != 0) && !d_eq);
        cycles_nxt = NCHUNK_C - CNT_W'(idx);
        if (!any_diff) begin
            res_nxt = RES_EQ;
        end else if (diff_gt) begin
            res_nxt = RES_GT;
        end else begin
            res_nxt = RES_LT;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; both ready/valid are pure functions of the state.
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        accept      = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (finish) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    release_out = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, digit walk, first-difference latch and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            idx        <= '0;
            found_q    <= 1'b0;
            found_gt_q <= 1'b0;
            res_q      <= '0;
            cycles_q   <= '0;
        end else begin
            if (accept) begin
                a_q        <= signed_mode ? (a ^ SIGN_MASK) : a;
                b_q        <= signed_mode ? (b ^ SIGN_MASK) : b;
                idx        <= LAST_IDX;
                found_q    <= 1'b0;
                found_gt_q <= 1'b0;
            end
            if (state == RUN) begin
                if (!found_q && !d_eq) begin
                    found_q    <= 1'b1;
                    found_gt_q <= d_gt;
                end
                if (finish) begin
                    res_q    <= res_nxt;
                    cycles_q <= cycles_nxt;
                end else begin
                    idx <= idx - IDX_W'(1);
                end
            end
            if (release_out) begin
                res_q    <= '0;
                cycles_q <= '0;
            end
        end
    end

    // Result outputs come straight from registers so they cannot glitch while held.
    always_comb begin
        eq     = |(res_q & RES_EQ);
        gt     = |(res_q & RES_GT);
        lt     = |(res_q & RES_LT);
        cycles = cycles_q;
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
module tb_seq_magnitude_comparator;

    logic        clk;
    logic        rst_n;
    logic        in_valid_s  [3];
    logic        in_ready_s  [3];
    logic [31:0] a_s         [3];
    logic [31:0] b_s         [3];
    logic        sm_s        [3];
    logic        out_valid_s [3];
    logic        out_ready_s [3];
    logic        eq_s        [3];
    logic        gt_s        [3];
    logic        lt_s        [3];
    logic [2:0]  cyc0;
    logic [2:0]  cyc1;
    logic [3:0]  cyc2;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit, byte digits, early exit
    seq_magnitude_comparator #(.WIDTH(32), .DIGIT(8), .EARLY_EXIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .a(a_s[0]), .b(b_s[0]), .signed_mode(sm_s[0]), .out_valid(out_valid_s[0]),
        .out_ready(out_ready_s[0]), .eq(eq_s[0]), .gt(gt_s[0]), .lt(lt_s[0]), .cycles(cyc0));

    // 32-bit, byte digits, constant latency
    seq_magnitude_comparator #(.WIDTH(32), .DIGIT(8), .EARLY_EXIT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .a(a_s[1]), .b(b_s[1]), .signed_mode(sm_s[1]), .out_valid(out_valid_s[1]),
        .out_ready(out_ready_s[1]), .eq(eq_s[1]), .gt(gt_s[1]), .lt(lt_s[1]), .cycles(cyc1));

    // 8-bit, bit-serial, early exit
    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .a(a_s[2][7:0]), .b(b_s[2][7:0]), .signed_mode(sm_s[2]), .out_valid(out_valid_s[2]),
        .out_ready(out_ready_s[2]), .eq(eq_s[2]), .gt(gt_s[2]), .lt(lt_s[2]), .cycles(cyc2));

    function automatic logic [31:0] cyc_of(input int u);
        case (u)
            0:       return 32'(cyc0);
            1:       return 32'(cyc1);
            default: return 32'(cyc2);
        endcase
    endfunction

    function automatic logic [2:0] res_of(input int u);
        return {lt_s[u], gt_s[u], eq_s[u]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one transaction, scramble inputs afterwards, then measure latency and check the result.
    task automatic run(input int u, input logic [31:0] av, input logic [31:0] bv, input logic sm,
                       input logic [2:0] exp_res, input int exp_cyc, input string tag);
        int n;
        check({tag, "_in_ready"}, 32'(in_ready_s[u]), 32'd1);
        a_s[u] = av;
        b_s[u] = bv;
        sm_s[u] = sm;
        in_valid_s[u] = 1'b1;
        @(posedge clk); #1;
        in_valid_s[u] = 1'b0;
        a_s[u] = ~av;
        b_s[u] = bv ^ 32'h5a5a_5a5a;
        sm_s[u] = ~sm;
        n = 0;
        while (!out_valid_s[u] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_cyc));
        check({tag, "_result"}, 32'(res_of(u)), 32'(exp_res));
        check({tag, "_cycles"}, cyc_of(u), 32'(exp_cyc));
        check({tag, "_busy"}, 32'(in_ready_s[u]), 32'd0);
    endtask

    // Complete the output handshake and check the block is back in IDLE with cleared results.
    task automatic release_out(input int u, input string tag);
        out_ready_s[u] = 1'b1;
        @(posedge clk); #1;
        out_ready_s[u] = 1'b0;
        check({tag, "_rel_state"}, {30'd0, out_valid_s[u], in_ready_s[u]}, 32'b01);
        check({tag, "_rel_res"}, 32'(res_of(u)), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_s[i] = 1'b0;
            a_s[i] = '0;
            b_s[i] = '0;
            sm_s[i] = 1'b0;
            out_ready_s[i] = 1'b0;
        end
        #12;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // reset state
        check("rst_in_ready", 32'(in_ready_s[0]), 32'd1);
        check("rst_out_valid", 32'(out_valid_s[0]), 32'd0);
        check("rst_res", 32'(res_of(0)), 32'd0);
        check("rst_cycles", cyc_of(0), 32'd0);

        // full scan, difference only in the last byte
        run(0, 32'h1234_5678, 32'h1234_5677, 1'b0, 3'b010, 4, "u_gt_lsb");
        release_out(0, "u_gt_lsb");

        // MSB differs: unsigned says greater, signed says less
        run(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b010, 1, "u_gt_msb");
        release_out(0, "u_gt_msb");
        run(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b100, 1, "s_lt_msb");
        release_out(0, "s_lt_msb");
        // -1 < 1 signed
        run(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b100, 1, "s_m1_lt_1");
        release_out(0, "s_m1_lt_1");

        // equal operands, unsigned
        run(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'b001, 4, "u_eq");
        release_out(0, "u_eq");

        // equal operands, signed, with 5 cycles of backpressure and ignored in_valid
        run(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 3'b001, 4, "s_eq_bp");
        in_valid_s[0] = 1'b1;
        a_s[0] = 32'h0000_0001;
        b_s[0] = 32'h0000_0002;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_hold", {25'd0, out_valid_s[0], in_ready_s[0], res_of(0)}, {25'd0, 1'b1, 1'b0, 3'b001});
            check("bp_cycles", cyc_of(0), 32'd4);
        end
        in_valid_s[0] = 1'b0;
        release_out(0, "bp");
        @(posedge clk); #1;
        check("bp_single", {30'd0, out_valid_s[0], in_ready_s[0]}, 32'b01);

        // reset while RUN is at index 2
        a_s[0] = 32'h0000_0005;
        b_s[0] = 32'h0000_0009;
        sm_s[0] = 1'b0;
        in_valid_s[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", 32'(in_ready_s[0]), 32'd0);
        rst_n = 1'b0;
        #2;
        check("arst_state", {30'd0, out_valid_s[0], in_ready_s[0]}, 32'b01);
        check("arst_res", 32'(res_of(0)), 32'd0);
        check("arst_cycles", cyc_of(0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", {30'd0, out_valid_s[0], in_ready_s[0]}, 32'b01);
        run(0, 32'h0000_0005, 32'h0000_0009, 1'b0, 3'b100, 4, "post_rst_lt");
        release_out(0, "post_rst_lt");

        // constant-latency instance
        run(1, 32'h0100_0000, 32'h0000_0000, 1'b0, 3'b010, 4, "ne_gt_msb");
        release_out(1, "ne_gt_msb");
        // every digit differs; only the first may decide
        run(1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b100, 4, "ne_s_lt");
        release_out(1, "ne_s_lt");
        run(1, 32'hCAFE_0000, 32'hCAFE_0000, 1'b0, 3'b001, 4, "ne_eq");
        release_out(1, "ne_eq");

        // bit-serial instance: 100 = 0110_0100, 20 = 0001_0100, differ at bit 6
        run(2, 32'd100, 32'd20, 1'b0, 3'b010, 2, "bit_gt");
        release_out(2, "bit_gt");
        run(2, 32'h80, 32'h7F, 1'b1, 3'b100, 1, "bit_s_lt");
        release_out(2, "bit_s_lt");
        run(2, 32'h5A, 32'h5A, 1'b0, 3'b001, 8, "bit_eq");
        release_out(2, "bit_eq");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
